fifo_drain_arbiter: RTL and testbench
=====================================

FIFO_DRAIN_ARBITER -- requirements
Module: fifo_drain_arbiter

Interface
REQ-001 Parameter MAIN_SIZE, default 8: width of each FIFO data word and of data_out.
REQ-002 Parameter BURST, default 4: maximum consecutive pops granted to one FIFO per grant; legal range 1..15.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Ports empty0 and empty1, input, 1 each: FIFO #0 and #1 empty flags; each flag reflects all pops issued up to the previous cycle.
REQ-006 Ports almost_full0 and almost_full1, input, 1 each: FIFO #0 and #1 almost-full flags.
REQ-007 Ports Error0 and Error1, input, 1 each: FIFO #0 and #1 overflow/underflow error flags.
REQ-008 Ports fifo_out0 and fifo_out1, input, MAIN_SIZE each: FIFO read data, valid one cycle after the corresponding pop.
REQ-009 Port ready, input, 1: downstream can accept data.
REQ-010 Ports pop0 and pop1, output, 1 each: read strobes to FIFO #0 and #1.
REQ-011 Port data_out, output, MAIN_SIZE: registered drained word.
REQ-012 Port valid_out, output, 1: data_out is valid this cycle.
REQ-013 Port src_out, output, 1: source FIFO of data_out (0 or 1).
REQ-014 Port pause, output, 1: registered OR of almost_full0 and almost_full1, driven to upstream.
REQ-015 Port err_sticky, output, 2: per-FIFO sticky error; bit0 is FIFO #0, bit1 is FIFO #1.

Function
REQ-016 FSM states: IDLE, SRV0, SRV1.
REQ-017 Arbitration point: any cycle in IDLE, or a cycle where SRVx exits.
- Candidates are the non-empty FIFOs.
- If both are candidates, the FIFO not last served wins.
- If only one is a candidate, it wins.
- If neither is a candidate, next state is IDLE.
REQ-018 last_served updates to x on every entry into SRVx.
REQ-019 In SRVx, popx is asserted combinationally when ready=1 and emptyx=0; pop0 and pop1 are never asserted together.
REQ-020 A 4-bit burst counter clears on every entry into SRVx and increments on every popx.
REQ-021 SRVx exits when the cycle's pop makes the count equal BURST, or when emptyx=1; on exit, arbitration runs in the same cycle.
- A winner of y enters SRVy next cycle.
- A winner of x re-enters SRVx with a fresh burst.
REQ-022 With ready=0 in SRVx: no pop, no count change, state held.
REQ-023 Pipeline latency is fixed.
- Pop at cycle N; FIFO data valid at N+1.
- data_out, src_out and valid_out=1 registered at N+2.
- valid_out=0 in any cycle with no pop two cycles earlier.
REQ-024 Downstream must absorb up to 2 words after deasserting ready; the block has no skid buffer.
REQ-025 No pop is ever issued to a FIFO whose empty flag is 1 in that cycle.
REQ-026 err_sticky[i] sets on any cycle with Errori=1 and clears only on reset.
REQ-027 pause equals the registered value of (almost_full0|almost_full1), giving 1 cycle of latency.

Reset
REQ-028 On reset=0 the block asynchronously forces:
- state to IDLE and last_served to 1, so FIFO #0 wins the first tie;
- burst count to 0;
- the pipeline stage clear;
- pop0=pop1=0, valid_out=0, data_out=0, src_out=0, pause=0, err_sticky=0.
REQ-029 Reset asserted mid-burst discards all in-flight words; no valid_out follows for pops issued before reset.
REQ-030 The first arbitration after reset release occurs on the first rising clk edge with reset=1.

Configuration
REQ-031 Macro ARB_STRICT_PRIO_EN defined: at every arbitration point, FIFO #0 wins whenever it is non-empty; last_served is ignored; the BURST limit still applies to both FIFOs.
REQ-032 Macro ARB_STRICT_PRIO_EN undefined: round-robin arbitration per REQ-017.

Verification
REQ-033 Single source:
- Stimulus: FIFO #0 holds 3 words (0xA1, 0xA2, 0xA3), FIFO #1 empty, ready=1, BURST=4.
- Response: pop0 high 3 cycles; data_out A1, A2, A3 with src_out=0 starting 2 cycles after the first pop; then IDLE.
REQ-034 Round-robin:
- Stimulus: both FIFOs hold 6 words, BURST=4, macro undefined.
- Response: pop order is 4×FIFO#0, 4×FIFO#1, 2×FIFO#0, 2×FIFO#1, with no idle cycle between bursts.
REQ-035 Strict priority:
- Stimulus: same as REQ-034 with ARB_STRICT_PRIO_EN defined.
- Response: pop order is 4×FIFO#0, 2×FIFO#0, 6×FIFO#1.
REQ-036 Backpressure:
- Stimulus: ready deasserted for 3 cycles after the 2nd pop of a burst.
- Response: no pops during those 3 cycles; burst count held at 2; at most 2 valid_out words during the stall; the burst resumes with 2 remaining pops.
REQ-037 Reset mid-burst:
- Stimulus: reset=0 asynchronously between clock edges after pop 2.
- Response: all outputs 0 immediately; no valid_out after release until new pops occur.
REQ-038 Errors and pause:
- Stimulus: Error1 pulses for 1 cycle; almost_full0 is held high.
- Response: err_sticky=2'b10 persists until reset; pause=1 one cycle after almost_full0 rises.

Source files
------------

// File: rtl/fifo_drain_arbiter.sv
// Drains two FIFOs into one registered output stream under a burst-limited round-robin arbiter.
// Define ARB_STRICT_PRIO_EN to make FIFO #0 win every arbitration in which it is non-empty.
module fifo_drain_arbiter #(
    parameter int MAIN_SIZE = 8,
    parameter int BURST     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 empty0,
    input  logic                 empty1,
    input  logic                 almost_full0,
    input  logic                 almost_full1,
    input  logic                 Error0,
    input  logic                 Error1,
    input  logic [MAIN_SIZE-1:0] fifo_out0,
    input  logic [MAIN_SIZE-1:0] fifo_out1,
    input  logic                 ready,
    output logic                 pop0,
    output logic                 pop1,
    output logic [MAIN_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic                 src_out,
    output logic                 pause,
    output logic [1:0]           err_sticky
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SRV0 = 2'd1,
        SRV1 = 2'd2
    } state_t;

    localparam logic [3:0] BURST_LIM = 4'(BURST);

    state_t     state, state_nxt;
    logic       last_served, last_nxt;
    logic [3:0] burst_cnt, cnt_nxt, cnt_inc;
    logic       arb, win, win_valid;
    logic       pop_d, src_d;

    // Winner of an arbitration point, used only when arb is asserted.
    always_comb begin
        win_valid = !empty0 || !empty1;
`ifdef ARB_STRICT_PRIO_EN
        win = empty0;
`else
        win = (!empty0 && !empty1) ? ~last_served : empty0;
`endif
    end

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        pop0      = 1'b0;
        pop1      = 1'b0;
        arb       = 1'b0;
        state_nxt = state;
        last_nxt  = last_served;
        cnt_inc   = burst_cnt + 4'd1;
        cnt_nxt   = burst_cnt;
        case (state)
            IDLE: arb = 1'b1;
            SRV0: begin
                pop0 = ready && !empty0;
                if (pop0) cnt_nxt = cnt_inc;
                arb = (pop0 && cnt_inc == BURST_LIM) || empty0;
            end
            SRV1: begin
                pop1 = ready && !empty1;
                if (pop1) cnt_nxt = cnt_inc;
                arb = (pop1 && cnt_inc == BURST_LIM) || empty1;
            end
            default: state_nxt = IDLE;
        endcase
        if (arb) begin
            if (win_valid) begin
                state_nxt = win ? SRV1 : SRV0;
                last_nxt  = win;
                cnt_nxt   = 4'd0;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            last_served <= 1'b1;
            burst_cnt   <= 4'd0;
        end else begin
            state       <= state_nxt;
            last_served <= last_nxt;
            burst_cnt   <= cnt_nxt;
        end
    end

    // Stage 1 remembers the pop while the FIFO presents its word; stage 2 captures it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pop_d      <= 1'b0;
            src_d      <= 1'b0;
            valid_out  <= 1'b0;
            data_out   <= '0;
            src_out    <= 1'b0;
            pause      <= 1'b0;
            err_sticky <= 2'b00;
        end else begin
            pop_d      <= pop0 || pop1;
            src_d      <= pop1;
            valid_out  <= pop_d;
            if (pop_d) begin
                data_out <= src_d ? fifo_out1 : fifo_out0;
                src_out  <= src_d;
            end
            pause      <= almost_full0 || almost_full1;
            err_sticky <= err_sticky | {Error1, Error0};
        end
    end

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Directed bench for fifo_drain_arbiter: FIFO models, pop/output logs and hand-derived expectations.
module tb_fifo_drain_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       empty0 = 1'b1, empty1 = 1'b1;
    logic       almost_full0, almost_full1, Error0, Error1, ready;
    logic [7:0] fifo_out0 = '0, fifo_out1 = '0;
    logic       pop0, pop1, valid_out, src_out, pause;
    logic [7:0] data_out;
    logic [1:0] err_sticky;

    int n_tests = 0;
    int n_fail  = 0;

    // FIFO models: the stimulus owns the write side, the model process owns the read side.
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
    int cyc = 0;
    int viol = 0;
    bit pop_src [$];
    int pop_cyc [$];
    logic [7:0] out_data [$];
    bit out_src [$];
    int out_cyc [$];

    fifo_drain_arbiter #(.MAIN_SIZE(8), .BURST(4)) dut (
        .clk(clk), .reset(reset),
        .empty0(empty0), .empty1(empty1),
        .almost_full0(almost_full0), .almost_full1(almost_full1),
        .Error0(Error0), .Error1(Error1),
        .fifo_out0(fifo_out0), .fifo_out1(fifo_out1),
        .ready(ready),
        .pop0(pop0), .pop1(pop1),
        .data_out(data_out), .valid_out(valid_out), .src_out(src_out),
        .pause(pause), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if ((pop0 && empty0) || (pop1 && empty1) || (pop0 && pop1)) viol++;
        if (pop0 && rd0 != wr0) begin
            fifo_out0 <= mem0[rd0 % 256];
            rd0++;
            pop_src.push_back(1'b0);
            pop_cyc.push_back(cyc);
        end
        if (pop1 && rd1 != wr1) begin
            fifo_out1 <= mem1[rd1 % 256];
            rd1++;
            pop_src.push_back(1'b1);
            pop_cyc.push_back(cyc);
        end
        empty0 <= (rd0 == wr0);
        empty1 <= (rd1 == wr1);
        cyc++;
    end

    always @(negedge clk) begin
        if (valid_out) begin
            out_data.push_back(data_out);
            out_src.push_back(src_out);
            out_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push0(input logic [7:0] d);
        mem0[wr0 % 256] = d;
        wr0++;
    endtask

    task automatic push1(input logic [7:0] d);
        mem1[wr1 % 256] = d;
        wr1++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        wr0 = rd0;
        wr1 = rd1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_pops(input int base, input int n, input int budget);
        int k = 0;
        while (pop_src.size() - base < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("pop_count_reached", pop_src.size() - base, n);
    endtask

    initial begin
        bit exp_rr [12];
        bit exp_bp [7];
        int pb, ob, k0, k1, stall_start, stall_cnt;
        logic [7:0] exp_d;

        reset = 1'b0;
        ready = 1'b0;
        almost_full0 = 1'b0; almost_full1 = 1'b0;
        Error0 = 1'b0; Error1 = 1'b0;
        #1;
        check("reset_outputs", {pop0, pop1, valid_out, src_out, pause, err_sticky, data_out}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Single source: three words from FIFO #0 only.
        ready = 1'b1;
        pb = pop_src.size();
        ob = out_data.size();
        push0(8'hA1); push0(8'hA2); push0(8'hA3);
        wait_pops(pb, 3, 20);
        repeat (6) @(negedge clk);
        check("single_pop_total", pop_src.size() - pb, 3);
        for (int i = 0; i < 3; i++) check("single_pop_src", pop_src[pb + i], 0);
        check("single_pop_span", pop_cyc[pb + 2] - pop_cyc[pb], 2);
        check("single_out_count", out_data.size() - ob, 3);
        check("single_out_d0", out_data[ob], 8'hA1);
        check("single_out_d1", out_data[ob + 1], 8'hA2);
        check("single_out_d2", out_data[ob + 2], 8'hA3);
        check("single_out_src", {out_src[ob], out_src[ob + 1], out_src[ob + 2]}, 0);
        check("single_latency", out_cyc[ob] - pop_cyc[pb], 2);
        check("single_idle_after", {pop0, pop1, valid_out}, 0);

        // Both FIFOs hold six words.
        do_reset();
`ifdef ARB_STRICT_PRIO_EN
        exp_rr = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
`else
        exp_rr = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
`endif
        pb = pop_src.size();
        ob = out_data.size();
        for (int i = 0; i < 6; i++) begin
            push0(8'h00 + 8'(i));
            push1(8'h10 + 8'(i));
        end
        wait_pops(pb, 12, 80);
        repeat (6) @(negedge clk);
        check("arb_out_count", out_data.size() - ob, 12);
        k0 = 0; k1 = 0;
        for (int i = 0; i < 12; i++) begin
            check("arb_pop_order", pop_src[pb + i], exp_rr[i]);
            exp_d = exp_rr[i] ? 8'h10 + 8'(k1) : 8'h00 + 8'(k0);
            if (exp_rr[i]) k1++; else k0++;
            check("arb_out_src", out_src[ob + i], exp_rr[i]);
            check("arb_out_data", out_data[ob + i], exp_d);
        end

        // Backpressure: ready drops for 3 cycles after the 2nd pop of a burst.
        do_reset();
        exp_bp = '{0, 0, 0, 0, 1, 0, 0};
        pb = pop_src.size();
        ob = out_data.size();
        for (int i = 0; i < 6; i++) push0(8'hB0 + 8'(i));
        push1(8'hC0);
        wait_pops(pb, 2, 30);
        ready = 1'b0;
        stall_start = cyc;
        repeat (3) @(negedge clk);
        check("bp_no_pop_in_stall", pop_src.size() - pb, 2);
        stall_cnt = 0;
        for (int i = ob; i < out_cyc.size(); i++)
            if (out_cyc[i] >= stall_start && out_cyc[i] < stall_start + 3) stall_cnt++;
        check("bp_stall_valid_le2", stall_cnt <= 2, 1);
        ready = 1'b1;
        wait_pops(pb, 7, 40);
        repeat (6) @(negedge clk);
        for (int i = 0; i < 7; i++) check("bp_pop_order", pop_src[pb + i], exp_bp[i]);
        check("bp_resume_gap", pop_cyc[pb + 2] - pop_cyc[pb + 1], 4);
        check("bp_out_count", out_data.size() - ob, 7);
        check("bp_out_d3", out_data[ob + 3], 8'hB3);
        check("bp_out_d4", out_data[ob + 4], 8'hC0);

        // Reset asserted between edges mid-burst.
        do_reset();
        pb = pop_src.size();
        for (int i = 0; i < 6; i++) push0(8'hD0 + 8'(i));
        wait_pops(pb, 2, 30);
        #2;
        reset = 1'b0;
        wr0 = rd0;
        wr1 = rd1;
        #1;
        check("rst_mid_outputs", {pop0, pop1, valid_out, src_out, pause, err_sticky, data_out}, 0);
        repeat (2) @(negedge clk);
        pb = pop_src.size();
        ob = out_data.size();
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_no_valid_after", out_data.size() - ob, 0);
        check("rst_no_pop_after", pop_src.size() - pb, 0);
        push0(8'hE0);
        wait_pops(pb, 1, 20);
        repeat (4) @(negedge clk);
        check("rst_new_out_count", out_data.size() - ob, 1);
        check("rst_new_out_data", out_data[ob], 8'hE0);

        // Sticky error and pause latency.
        @(negedge clk);
        Error1 = 1'b1;
        @(negedge clk);
        Error1 = 1'b0;
        check("err_sticky_set", err_sticky, 2'b10);
        repeat (5) @(negedge clk);
        check("err_sticky_hold", err_sticky, 2'b10);
        almost_full0 = 1'b1;
        #1;
        check("pause_before_edge", pause, 0);
        @(negedge clk);
        check("pause_after_edge", pause, 1);
        almost_full0 = 1'b0;
        do_reset();
        #1;
        check("err_sticky_cleared", err_sticky, 2'b00);
        check("pause_cleared", pause, 0);

        check("pop_safety_violations", viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
